// File: rtl/xadac_if.sv
// Shared xadac memory-interface types and OBI id tagging helpers.
package xadac_if;

  localparam int unsigned AddrWidth   = 32;
  localparam int unsigned VectorWidth = 128;
  localparam int unsigned IdWidth     = 4;
  // Widest master index the tagging helpers can carry; callers truncate.
  localparam int unsigned MaxMstIdxW  = 4;

  typedef logic [AddrWidth-1:0]          AddrT;
  typedef logic [VectorWidth-1:0]        VectorT;
  typedef logic [VectorWidth/8-1:0]      BeT;
  typedef logic [IdWidth-1:0]            IdT;
  typedef logic [MaxMstIdxW-1:0]         MstIdxT;
  typedef logic [IdWidth+MaxMstIdxW-1:0] TagIdT;

  // Slave-side id = {master index, master-local id}.
  function automatic TagIdT obi_tag_id(input MstIdxT idx, input IdT id);
    return {idx, id};
  endfunction

  // Master index carried in a tagged id.
  function automatic MstIdxT obi_tag_idx(input TagIdT tag);
    return tag[IdWidth +: MaxMstIdxW];
  endfunction

  // Master-local id carried in a tagged id.
  function automatic IdT obi_untag_id(input TagIdT tag);
    return tag[IdWidth-1:0];
  endfunction

endpackage

// File: rtl/xadac_rr_arb.sv
// Round-robin selector with lock override; owns the rotating priority pointer.
module xadac_rr_arb #(
  parameter  int unsigned N    = 2,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic [N-1:0]    elig,
  input  logic            lock,
  input  logic [IdxW-1:0] lock_idx,
  input  logic            advance,
  output logic [IdxW-1:0] sel,
  output logic            any
);

  logic [IdxW-1:0] r_rr_ptr;
  logic [IdxW-1:0] w_rr_sel;
  logic            w_found;

  // First eligible index at or after the pointer: scan upper part, then wrap to the lower part.
  always_comb begin
    w_rr_sel = r_rr_ptr;
    w_found  = 1'b0;
    for (int unsigned j = 0; j < N; j++) begin
      if (!w_found && elig[j] && (IdxW'(j) >= r_rr_ptr)) begin
        w_rr_sel = IdxW'(j);
        w_found  = 1'b1;
      end
    end
    for (int unsigned j = 0; j < N; j++) begin
      if (!w_found && elig[j]) begin
        w_rr_sel = IdxW'(j);
        w_found  = 1'b1;
      end
    end
  end

  assign sel = lock ? lock_idx : w_rr_sel;
  assign any = lock | (|elig);

  // Pointer moves just past the winner on each completed handshake; explicit wrap for non-power-of-2 N.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr <= '0;
    end else if (advance) begin
      r_rr_ptr <= (sel == IdxW'(N-1)) ? '0 : sel + 1'b1;
    end
  end

endmodule

// File: rtl/xadac_obi_arbiter.sv
// Shares one OBI memory port between NoMst xadac stages: round-robin A channel
// with address-phase lock, per-master outstanding limits, id-tagged R routing.
module xadac_obi_arbiter
  import xadac_if::*;
#(
  parameter  int unsigned NoMst    = 2,
  parameter  int unsigned MaxOutst = 4,
  localparam int unsigned MstIdxW  = $clog2(NoMst)
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [NoMst-1:0]           mst_req,
  output logic [NoMst-1:0]           mst_gnt,
  input  logic [NoMst-1:0]           mst_we,
  input  AddrT                       mst_addr  [NoMst],
  input  BeT                         mst_be    [NoMst],
  input  VectorT                     mst_wdata [NoMst],
  input  IdT                         mst_aid   [NoMst],
  output logic [NoMst-1:0]           mst_rvalid,
  input  logic [NoMst-1:0]           mst_rready,
  output IdT                         mst_rid   [NoMst],
  output VectorT                     mst_rdata,
  output logic                       slv_req,
  input  logic                       slv_gnt,
  output logic                       slv_we,
  output AddrT                       slv_addr,
  output BeT                         slv_be,
  output VectorT                     slv_wdata,
  output logic [IdWidth+MstIdxW-1:0] slv_aid,
  input  logic                       slv_rvalid,
  output logic                       slv_rready,
  input  logic [IdWidth+MstIdxW-1:0] slv_rid,
  input  VectorT                     slv_rdata
);

  localparam int unsigned CntW = $clog2(MaxOutst + 1);

  logic               r_lock;
  logic [MstIdxW-1:0] r_lock_idx;
  logic [CntW-1:0]    r_cnt [NoMst];

  logic [NoMst-1:0]   w_elig;
  logic [NoMst-1:0]   w_r_hs;
  logic [MstIdxW-1:0] w_sel;
  logic [MstIdxW-1:0] w_ridx;
  logic               w_any;
  logic               w_hs_a;
  logic               w_rid_ok;

  // A master competes only while it has headroom under the outstanding limit.
  always_comb begin
    w_elig = '0;
    for (int unsigned i = 0; i < NoMst; i++) begin
      w_elig[i] = mst_req[i] && (r_cnt[i] < CntW'(MaxOutst));
    end
  end

  xadac_rr_arb #(
    .N(NoMst)
  ) u_rr_arb (
    .clk      (clk),
    .rstn     (rstn),
    .elig     (w_elig),
    .lock     (r_lock),
    .lock_idx (r_lock_idx),
    .advance  (w_hs_a),
    .sel      (w_sel),
    .any      (w_any)
  );

  // Gated by rstn so a held request cannot reach memory while reset is asserted.
  assign slv_req = rstn && w_any;
  assign w_hs_a  = slv_req && slv_gnt;

  // Zero-latency A mux from the selected master; grant goes only to the winner.
  always_comb begin
    slv_we    = mst_we[w_sel];
    slv_addr  = mst_addr[w_sel];
    slv_be    = mst_be[w_sel];
    slv_wdata = mst_wdata[w_sel];
    slv_aid   = {w_sel, mst_aid[w_sel]};
    mst_gnt   = '0;
    for (int unsigned i = 0; i < NoMst; i++) begin
      mst_gnt[i] = w_hs_a && (w_sel == MstIdxW'(i));
    end
  end

  // Address phase stays pinned to the stalled master until memory grants it.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_lock     <= 1'b0;
      r_lock_idx <= '0;
    end else if (slv_req && !slv_gnt) begin
      r_lock     <= 1'b1;
      r_lock_idx <= w_sel;
    end else if (w_hs_a) begin
      r_lock     <= 1'b0;
    end
  end

  assign w_ridx   = slv_rid[IdWidth+MstIdxW-1 -: MstIdxW];
  assign w_rid_ok = 32'(w_ridx) < NoMst;

  // R routing by the tag in the upper rid bits; an unknown tag is sunk with rready=1.
  always_comb begin
    mst_rvalid = '0;
    slv_rready = 1'b1;
    for (int unsigned i = 0; i < NoMst; i++) begin
      mst_rid[i] = slv_rid[IdWidth-1:0];
      if (w_ridx == MstIdxW'(i)) begin
        mst_rvalid[i] = slv_rvalid;
        slv_rready    = mst_rready[i];
      end
    end
  end

  assign w_r_hs    = mst_rvalid & mst_rready;
  assign mst_rdata = slv_rdata;

  // In-flight count per master: +1 on A handshake, -1 on R handshake, saturating at 0.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int unsigned i = 0; i < NoMst; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NoMst; i++) begin
        if (mst_gnt[i] && !w_r_hs[i]) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (!mst_gnt[i] && w_r_hs[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  a_aphase_stable: assert property (@(posedge clk) disable iff (!rstn)
    (slv_req && !slv_gnt) |=> $stable({slv_addr, slv_be, slv_wdata, slv_aid}));

  a_rid_in_range: assert property (@(posedge clk) disable iff (!rstn)
    slv_rvalid |-> w_rid_ok);

  for (genvar gi = 0; gi < NoMst; gi++) begin : g_cnt_chk
    a_cnt_limit: assert property (@(posedge clk) disable iff (!rstn)
      (r_cnt[gi] <= CntW'(MaxOutst)));
    a_cnt_underflow: assert property (@(posedge clk) disable iff (!rstn)
      !(w_r_hs[gi] && !mst_gnt[gi] && (r_cnt[gi] == '0)));
  end

endmodule

// File: tb/tb_xadac_obi_arbiter.sv
// Directed bench for xadac_obi_arbiter with a per-cycle reference model.
module tb_xadac_obi_arbiter;
  import xadac_if::*;

  localparam int NoMst    = 2;
  localparam int MaxOutst = 4;
  localparam int MstIdxW  = 1;
  localparam int SidW     = IdWidth + MstIdxW;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [NoMst-1:0] mst_req, mst_gnt, mst_we, mst_rvalid, mst_rready;
  AddrT             mst_addr  [NoMst];
  BeT               mst_be    [NoMst];
  VectorT           mst_wdata [NoMst];
  IdT               mst_aid   [NoMst];
  IdT               mst_rid   [NoMst];
  VectorT           mst_rdata, slv_wdata, slv_rdata;
  logic             slv_req, slv_gnt, slv_we, slv_rvalid, slv_rready;
  AddrT             slv_addr;
  BeT               slv_be;
  logic [SidW-1:0]  slv_aid, slv_rid;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Reference model: rotating priority, locked master (-1 = none), outstanding counts.
  int m_ptr  = 0;
  int m_lock = -1;
  int m_cnt [NoMst] = '{default: 0};

  xadac_obi_arbiter #(
    .NoMst    (NoMst),
    .MaxOutst (MaxOutst)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .mst_req    (mst_req),
    .mst_gnt    (mst_gnt),
    .mst_we     (mst_we),
    .mst_addr   (mst_addr),
    .mst_be     (mst_be),
    .mst_wdata  (mst_wdata),
    .mst_aid    (mst_aid),
    .mst_rvalid (mst_rvalid),
    .mst_rready (mst_rready),
    .mst_rid    (mst_rid),
    .mst_rdata  (mst_rdata),
    .slv_req    (slv_req),
    .slv_gnt    (slv_gnt),
    .slv_we     (slv_we),
    .slv_addr   (slv_addr),
    .slv_be     (slv_be),
    .slv_wdata  (slv_wdata),
    .slv_aid    (slv_aid),
    .slv_rvalid (slv_rvalid),
    .slv_rready (slv_rready),
    .slv_rid    (slv_rid),
    .slv_rdata  (slv_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Which master the model says owns the A channel this cycle (-1 = nobody).
  function automatic int model_sel();
    if (m_lock >= 0) return m_lock;
    for (int k = 0; k < NoMst; k++) begin
      int j;
      j = (m_ptr + k) % NoMst;
      if (mst_req[j] && (m_cnt[j] < MaxOutst)) return j;
    end
    return -1;
  endfunction

  function automatic int rid_idx();
    return int'(slv_rid) >> IdWidth;
  endfunction

  // Model state update at each clock edge, cleared asynchronously by reset.
  initial forever begin
    @(posedge clk or negedge rstn);
    if (!rstn) begin
      m_ptr  = 0;
      m_lock = -1;
      for (int i = 0; i < NoMst; i++) m_cnt[i] = 0;
    end else begin
      int s, r;
      s = model_sel();
      r = rid_idx();
      if (s >= 0) begin
        if (slv_gnt) begin
          m_cnt[s] = m_cnt[s] + 1;
          m_ptr    = (s + 1) % NoMst;
          m_lock   = -1;
        end else begin
          m_lock = s;
        end
      end
      if (slv_rvalid && (r < NoMst) && mst_rready[r] && (m_cnt[r] > 0)) m_cnt[r] = m_cnt[r] - 1;
    end
  end

  // Compare every DUT output against the model on each falling edge out of reset.
  initial forever begin
    @(negedge clk);
    if (rstn) begin
      int s, r;
      logic [NoMst-1:0] eg, erv;
      s = model_sel();
      r = rid_idx();
      eg = '0;
      if ((s >= 0) && slv_gnt) eg[s] = 1'b1;
      erv = '0;
      if (slv_rvalid && (r < NoMst)) erv[r] = 1'b1;
      chk("m_slv_req", 128'(slv_req), 128'(s >= 0));
      chk("m_mst_gnt", 128'(mst_gnt), 128'(eg));
      if (s >= 0) begin
        chk("m_slv_addr", 128'(slv_addr), 128'(mst_addr[s]));
        chk("m_slv_we", 128'(slv_we), 128'(mst_we[s]));
        chk("m_slv_be", 128'(slv_be), 128'(mst_be[s]));
        chk("m_slv_wdata", slv_wdata, mst_wdata[s]);
        chk("m_slv_aid", 128'(slv_aid), 128'((s << IdWidth) | int'(mst_aid[s])));
      end
      chk("m_mst_rvalid", 128'(mst_rvalid), 128'(erv));
      chk("m_slv_rready", 128'(slv_rready), 128'((r < NoMst) ? mst_rready[r] : 1'b1));
      if (erv != '0) begin
        chk("m_mst_rid", 128'(mst_rid[r]), 128'(int'(slv_rid) % (1 << IdWidth)));
        chk("m_mst_rdata", mst_rdata, slv_rdata);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  task automatic idle();
    mst_req    = '0;
    slv_gnt    = 1'b0;
    slv_rvalid = 1'b0;
    mst_rready = '1;
  endtask

  task automatic set_a(input int m, input logic [31:0] addr, input logic we, input logic [3:0] id);
    mst_addr[m]  = addr;
    mst_we[m]    = we;
    mst_aid[m]   = id;
    mst_be[m]    = BeT'(16'hffff ^ addr[15:0]);
    mst_wdata[m] = {4{addr}};
  endtask

  // One-cycle response with tag idx and local id, accepted by an always-ready master.
  task automatic resp(input int idx, input int id);
    slv_rvalid = 1'b1;
    slv_rid    = SidW'((idx << IdWidth) | id);
    slv_rdata  = {$urandom, $urandom, $urandom, $urandom};
    tick();
    slv_rvalid = 1'b0;
  endtask

  initial begin
    idle();
    slv_rid   = '0;
    slv_rdata = '0;
    set_a(0, 32'h1000_0000, 1'b0, 4'h1);
    set_a(1, 32'h2000_0000, 1'b1, 4'h2);

    // Reset: requests and grant held high must not leak to either side.
    mst_req = '1;
    slv_gnt = 1'b1;
    #12;
    chk("rst_slv_req", 128'(slv_req), 128'(0));
    chk("rst_mst_gnt", 128'(mst_gnt), 128'(0));
    chk("rst_mst_rvalid", 128'(mst_rvalid), 128'(0));
    chk("tag_fn", 128'(obi_tag_id(MstIdxT'(1), IdT'(3))), 128'(8'h13));
    chk("tag_idx_fn", 128'(obi_tag_idx(TagIdT'(8'h5a))), 128'(4'h5));
    chk("untag_id_fn", 128'(obi_untag_id(TagIdT'(8'h5a))), 128'(4'ha));
    #10;
    idle();
    rstn = 1'b1;
    tick();

    // 1: both request continuously -> alternating grants and aid MSB.
    mst_req = '1;
    slv_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_a(0, 32'h1000_0010 + 32'(c), 1'b0, 4'(c));
      set_a(1, 32'h2000_0010 + 32'(c), 1'b1, 4'(c + 8));
      at_neg();
      chk("t1_gnt", 128'(mst_gnt), 128'(((c % 2) == 0) ? 2'b01 : 2'b10));
      chk("t1_aid_msb", 128'(slv_aid[SidW-1]), 128'(c % 2));
      tick();
    end
    idle();
    resp(0, 0); resp(1, 8); resp(0, 2); resp(1, 10);

    // 2: m0 stalls 3 cycles, m1 joins mid-way; m0 keeps the address phase.
    set_a(0, 32'h1000_0100, 1'b0, 4'h4);
    set_a(1, 32'h2000_0100, 1'b1, 4'h6);
    mst_req = 2'b01;
    for (int c = 0; c < 4; c++) begin
      if (c == 1) mst_req = 2'b11;
      if (c == 3) slv_gnt = 1'b1;
      at_neg();
      chk("t2_addr", 128'(slv_addr), 128'(32'h1000_0100));
      chk("t2_gnt", 128'(mst_gnt), 128'((c == 3) ? 2'b01 : 2'b00));
      tick();
    end
    set_a(0, 32'h1000_0104, 1'b0, 4'h5);
    at_neg();
    chk("t2_next_gnt", 128'(mst_gnt), 128'(2'b10));
    chk("t2_next_addr", 128'(slv_addr), 128'(32'h2000_0100));
    tick();
    idle();
    resp(0, 4); resp(1, 6);

    // 3: m0 fills its 4 slots; 5th waits for one response.
    mst_req = 2'b01;
    slv_gnt = 1'b1;
    for (int c = 0; c < 4; c++) begin
      set_a(0, 32'h1000_0200 + 32'(4 * c), 1'b1, 4'(c));
      at_neg();
      chk("t3_fill_gnt", 128'(mst_gnt), 128'(2'b01));
      tick();
    end
    set_a(0, 32'h1000_0210, 1'b1, 4'h7);
    at_neg();
    chk("t3_masked_req", 128'(slv_req), 128'(0));
    chk("t3_masked_gnt", 128'(mst_gnt), 128'(0));
    tick();
    slv_rvalid = 1'b1;
    slv_rid    = SidW'(7);
    slv_rdata  = {4{32'hd00d_f00d}};
    at_neg();
    chk("t3_resp_req", 128'(slv_req), 128'(0));
    chk("t3_resp_rvalid", 128'(mst_rvalid), 128'(2'b01));
    tick();
    slv_rvalid = 1'b0;
    at_neg();
    chk("t3_fifth_gnt", 128'(mst_gnt), 128'(2'b01));
    tick();
    idle();
    resp(0, 0); resp(0, 1); resp(0, 2); resp(0, 3);

    // 4: response to m1 back-pressured for 2 cycles.
    set_a(1, 32'h2000_0300, 1'b0, 4'h3);
    mst_req = 2'b10;
    slv_gnt = 1'b1;
    at_neg();
    chk("t4_a_gnt", 128'(mst_gnt), 128'(2'b10));
    tick();
    idle();
    slv_rvalid    = 1'b1;
    slv_rid       = SidW'((1 << IdWidth) | 3);
    slv_rdata     = {4{32'h0bad_cafe}};
    mst_rready[1] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) mst_rready[1] = 1'b1;
      at_neg();
      chk("t4_rready", 128'(slv_rready), 128'((c == 2) ? 1'b1 : 1'b0));
      chk("t4_rvalid", 128'(mst_rvalid), 128'(2'b10));
      chk("t4_rid", 128'(mst_rid[1]), 128'(3));
      tick();
    end
    idle();

    // 5: m1 at cnt=2 takes an A and an R handshake together -> still 2 slots left.
    mst_req = 2'b10;
    slv_gnt = 1'b1;
    for (int c = 0; c < 2; c++) begin
      set_a(1, 32'h2000_0400 + 32'(4 * c), 1'b1, 4'(c));
      at_neg();
      chk("t5_pre_gnt", 128'(mst_gnt), 128'(2'b10));
      tick();
    end
    set_a(1, 32'h2000_0408, 1'b1, 4'h2);
    slv_rvalid = 1'b1;
    slv_rid    = SidW'((1 << IdWidth) | 0);
    at_neg();
    chk("t5_both_gnt", 128'(mst_gnt), 128'(2'b10));
    chk("t5_both_rvalid", 128'(mst_rvalid), 128'(2'b10));
    tick();
    slv_rvalid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_a(1, 32'h2000_0410 + 32'(4 * c), 1'b1, 4'(c + 3));
      at_neg();
      chk("t5_tail_req", 128'(slv_req), 128'((c < 2) ? 1'b1 : 1'b0));
      tick();
    end
    idle();
    resp(1, 1); resp(1, 2); resp(1, 3); resp(1, 4);

    // 6: reset pulse while m0 is locked with 3 in flight.
    mst_req = 2'b01;
    slv_gnt = 1'b1;
    for (int c = 0; c < 3; c++) begin
      set_a(0, 32'h1000_0500 + 32'(4 * c), 1'b0, 4'(c));
      at_neg();
      chk("t6_pre_gnt", 128'(mst_gnt), 128'(2'b01));
      tick();
    end
    set_a(0, 32'h1000_0600, 1'b0, 4'h9);
    slv_gnt = 1'b0;
    at_neg();
    chk("t6_lock_req", 128'(slv_req), 128'(1));
    tick();
    #2;
    rstn    = 1'b0;
    slv_gnt = 1'b1;
    #1;
    chk("t6_rst_req", 128'(slv_req), 128'(0));
    chk("t6_rst_gnt", 128'(mst_gnt), 128'(0));
    #3;
    idle();
    rstn = 1'b1;
    tick();
    mst_req = 2'b11;
    slv_gnt = 1'b1;
    at_neg();
    chk("t6_ptr_zero", 128'(mst_gnt), 128'(2'b01));
    tick();
    mst_req = 2'b01;
    for (int c = 0; c < 4; c++) begin
      set_a(0, 32'h1000_0700 + 32'(4 * c), 1'b0, 4'(c));
      at_neg();
      chk("t6_cnt_zero", 128'(mst_gnt), 128'((c < 3) ? 2'b01 : 2'b00));
      tick();
    end
    idle();
    resp(0, 0); resp(0, 1); resp(0, 2); resp(0, 3);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
